seq_timing_unit: RTL and testbench

- Upstream neighbour of the basic-computer control logic; generates every timing and decode input that block consumes.
- Holds the 4-bit sequence counter (SC), the run flip-flop (S), the opcode/indirect latches and the interrupt flip-flops (IEN, R).
- Drives one-hot `seq`, decoded `op`, `ind` and `ir_addr` to the control logic, and accepts `sc_inc`/`sc_clr` back from it.

---
 rtl/basic_computer_pkg.sv | 33 +++
 rtl/sc_counter_decoder.sv | 51 +++++
 rtl/seq_timing_unit.sv | 111 +++++++++++
 tb/tb_seq_timing_unit.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/basic_computer_pkg.sv
// Shared constants, opcode encodings and IR field helpers for the basic computer.
`timescale 1ns/1ps
package basic_computer_pkg;

  localparam int SC_W   = 4;
  localparam int N_T    = 16;
  localparam int OPC_W  = 3;
  localparam int IR_W   = 16;
  localparam int ADDR_W = 12;

  // Memory-reference opcode encodings (IR[14:12]); 7 selects register/IO group.
  localparam logic [OPC_W-1:0] AND    = 3'd0;
  localparam logic [OPC_W-1:0] ADD    = 3'd1;
  localparam logic [OPC_W-1:0] LDA    = 3'd2;
  localparam logic [OPC_W-1:0] STA    = 3'd3;
  localparam logic [OPC_W-1:0] BUN    = 3'd4;
  localparam logic [OPC_W-1:0] BSA    = 3'd5;
  localparam logic [OPC_W-1:0] ISZ    = 3'd6;
  localparam logic [OPC_W-1:0] REG_IO = 3'd7;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
    return ir[14:12];
  endfunction

  function automatic logic ir_indirect(input logic [IR_W-1:0] ir);
    return ir[15];
  endfunction

  function automatic logic [ADDR_W-1:0] ir_address(input logic [IR_W-1:0] ir);
    return ir[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sc_counter_decoder.sv
// Sequence counter with run flip-flop and one-hot timing decoder.
// SC only advances while running; halting forces SC back to zero.
`timescale 1ns/1ps
module sc_counter_decoder #(
  parameter int SC_W = 4,
  parameter int N_T  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           hlt,
  input  logic           sc_inc,
  input  logic           sc_clr,
  output logic [SC_W-1:0] sc,
  output logic           running,
  output logic [N_T-1:0] seq
);

  logic [SC_W-1:0] r_sc;
  logic            r_running;
  logic [N_T-1:0]  w_seq;

  // Run flip-flop and counter: hlt beats start, clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_sc      <= '0;
    end else if (hlt) begin
      r_running <= 1'b0;
      r_sc      <= '0;
    end else if (!r_running) begin
      r_sc <= '0;
      if (start) r_running <= 1'b1;
    end else if (sc_clr) begin
      r_sc <= '0;
    end else if (sc_inc) begin
      r_sc <= r_sc + 1'b1;
    end
  end

  // One-hot timing decode, gated by the run flip-flop.
  always_comb begin
    w_seq = '0;
    if (r_running) w_seq[r_sc] = 1'b1;
  end

  assign sc      = r_sc;
  assign running = r_running;
  assign seq     = w_seq;

endmodule

// File: rtl/seq_timing_unit.sv
// Timing and decode front end for the basic-computer control logic:
// sequence counter, opcode/indirect latch and interrupt flip-flops.
`timescale 1ns/1ps
module seq_timing_unit #(
  parameter int SC_W  = basic_computer_pkg::SC_W,
  parameter int N_T   = basic_computer_pkg::N_T,
  parameter int OPC_W = basic_computer_pkg::OPC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                hlt,
  input  logic                sc_inc,
  input  logic                sc_clr,
  input  logic [15:0]         ir,
  input  logic                ien_set,
  input  logic                ien_clr,
  input  logic                r_clr,
  input  logic                fgi,
  input  logic                fgo,
  output logic [N_T-1:0]      seq,
  output logic [2**OPC_W-1:0] op,
  output logic                ind,
  output logic [11:0]         ir_addr,
  output logic [SC_W-1:0]     sc,
  output logic                running,
  output logic                ien,
  output logic                r_int
);

  import basic_computer_pkg::*;

  logic [N_T-1:0]      w_seq;
  logic [SC_W-1:0]     w_sc;
  logic                w_running;
  logic [2**OPC_W-1:0] w_op_onehot;
  logic                w_r_set;

  logic [2**OPC_W-1:0] r_op;
  logic                r_ind;
  logic                r_ien;
  logic                r_r;

  sc_counter_decoder #(
    .SC_W (SC_W),
    .N_T  (N_T)
  ) u_sc (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hlt     (hlt),
    .sc_inc  (sc_inc),
    .sc_clr  (sc_clr),
    .sc      (w_sc),
    .running (w_running),
    .seq     (w_seq)
  );

  // Opcode decode of the live IR; only sampled at T2.
  always_comb begin
    w_op_onehot = '0;
    w_op_onehot[ir_opcode(ir)] = 1'b1;
  end

  // Interrupt request is only taken outside the fetch/decode slots T0..T2.
  assign w_r_set = w_running & r_ien & (fgi | fgo) &
                   ~(w_seq[0] | w_seq[1] | w_seq[2]) & ~r_clr;

  // Decode latch: capture opcode and indirect bit on the T2 edge, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_ind <= 1'b0;
    end else if (w_running && w_seq[2]) begin
      r_op  <= w_op_onehot;
      r_ind <= ir_indirect(ir);
    end
  end

  // Interrupt enable: IOF or end of interrupt cycle beats ION.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien <= 1'b0;
    end else if (ien_clr || r_clr) begin
      r_ien <= 1'b0;
    end else if (ien_set) begin
      r_ien <= 1'b1;
    end
  end

  // Interrupt-cycle flip-flop: any clear source beats a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= 1'b0;
    end else if (r_clr || hlt || !w_running) begin
      r_r <= 1'b0;
    end else if (w_r_set) begin
      r_r <= 1'b1;
    end
  end

  assign seq     = w_seq;
  assign sc      = w_sc;
  assign running = w_running;
  assign op      = r_op;
  assign ind     = r_ind;
  assign ien     = r_ien;
  assign r_int   = r_r;
  assign ir_addr = ir_address(ir);

endmodule

// File: tb/tb_seq_timing_unit.sv
// Directed bench for seq_timing_unit.
`timescale 1ns/1ps
module tb_seq_timing_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, hlt, sc_inc, sc_clr;
  logic [15:0] ir;
  logic        ien_set, ien_clr, r_clr, fgi, fgo;
  logic [15:0] seq;
  logic [7:0]  op;
  logic        ind;
  logic [11:0] ir_addr;
  logic [3:0]  sc;
  logic        running, ien, r_int;

  int checks = 0;
  int errors = 0;

  seq_timing_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hlt(hlt), .sc_inc(sc_inc),
    .sc_clr(sc_clr), .ir(ir), .ien_set(ien_set), .ien_clr(ien_clr),
    .r_clr(r_clr), .fgi(fgi), .fgo(fgo), .seq(seq), .op(op), .ind(ind),
    .ir_addr(ir_addr), .sc(sc), .running(running), .ien(ien), .r_int(r_int)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; hlt = 0; sc_inc = 0; sc_clr = 0; ir = 16'h0000;
    ien_set = 0; ien_clr = 0; r_clr = 0; fgi = 0; fgo = 0;
    step(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0b exp=0", running); end
    checks++; if (seq !== 16'h0000) begin errors++; $display("FAIL reset_seq got=%h exp=0000", seq); end
    checks++; if (op !== 8'h00) begin errors++; $display("FAIL reset_op got=%h exp=00", op); end
    checks++; if ({ind, ien, r_int} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ind, ien, r_int}); end
    #2 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_start_seq();
    ir = 16'h9123;
    start = 1; step(1); start = 0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got=%0b exp=1", running); end
    checks++; if (seq !== 16'h0001) begin errors++; $display("FAIL seq_t0 got=%h exp=0001", seq); end
    sc_inc = 1; step(1);
    checks++; if (seq !== 16'h0002) begin errors++; $display("FAIL seq_t1 got=%h exp=0002", seq); end
    step(1);
    checks++; if (seq !== 16'h0004) begin errors++; $display("FAIL seq_t2 got=%h exp=0004", seq); end
  endtask

  task automatic test_decode();
    step(1);  // T2 edge -> T3
    checks++; if (seq !== 16'h0008) begin errors++; $display("FAIL seq_t3 got=%h exp=0008", seq); end
    checks++; if (op !== 8'h02) begin errors++; $display("FAIL decode_op got=%h exp=02", op); end
    checks++; if (ind !== 1'b1) begin errors++; $display("FAIL decode_ind got=%0b exp=1", ind); end
    checks++; if (ir_addr !== 12'h123) begin errors++; $display("FAIL ir_addr_a got=%h exp=123", ir_addr); end
    step(1);  // now T4
    ir = 16'h7800; #1;
    checks++; if (ir_addr !== 12'h800) begin errors++; $display("FAIL ir_addr_b got=%h exp=800", ir_addr); end
    step(1);  // T5
    checks++; if (op !== 8'h02 || ind !== 1'b1) begin errors++; $display("FAIL decode_hold got=%h/%0b exp=02/1", op, ind); end
  endtask

  task automatic test_wrap();
    step(10);  // T5 -> T15
    checks++; if (sc !== 4'd15 || seq !== 16'h8000) begin errors++; $display("FAIL sc_15 got=%0d/%h exp=15/8000", sc, seq); end
    step(1);
    checks++; if (sc !== 4'd0 || seq !== 16'h0001) begin errors++; $display("FAIL sc_wrap got=%0d/%h exp=0/0001", sc, seq); end
    step(3);  // through T2 with ir=7800 -> REG_IO, direct
    checks++; if (op !== 8'h80 || ind !== 1'b0) begin errors++; $display("FAIL relatch got=%h/%0b exp=80/0", op, ind); end
    step(2);  // T5
    checks++; if (sc !== 4'd5) begin errors++; $display("FAIL sc_t5 got=%0d exp=5", sc); end
    sc_clr = 1; step(1); sc_clr = 0;
    checks++; if (sc !== 4'd0 || seq !== 16'h0001) begin errors++; $display("FAIL clr_priority got=%0d/%h exp=0/0001", sc, seq); end
    sc_inc = 0;
  endtask

  task automatic test_halt();
    step(1);
    checks++; if (sc !== 4'd0) begin errors++; $display("FAIL hold_sc got=%0d exp=0", sc); end
    hlt = 1; start = 1; sc_inc = 1; step(1); hlt = 0; start = 0;
    checks++; if (running !== 1'b0 || seq !== 16'h0000) begin errors++; $display("FAIL hlt_wins got=%0b/%h exp=0/0000", running, seq); end
    step(2);  // sc_inc ignored while halted
    checks++; if (sc !== 4'd0 || running !== 1'b0) begin errors++; $display("FAIL halted_frozen got=%0d/%0b exp=0/0", sc, running); end
    checks++; if (op !== 8'h80) begin errors++; $display("FAIL op_across_halt got=%h exp=80", op); end
    sc_inc = 0; start = 1; step(1); start = 0;
    checks++; if (seq !== 16'h0001) begin errors++; $display("FAIL restart got=%h exp=0001", seq); end
    start = 1; step(1); start = 0;  // ignored while running
    checks++; if (seq !== 16'h0001 || running !== 1'b1) begin errors++; $display("FAIL start_ignored got=%h/%0b exp=0001/1", seq, running); end
  endtask

  task automatic test_interrupt();
    ien_set = 1; step(1); ien_set = 0;
    checks++; if (ien !== 1'b1) begin errors++; $display("FAIL ien_set got=%0b exp=1", ien); end
    sc_inc = 1; step(1); sc_inc = 0;  // T1
    fgi = 1; step(1);
    checks++; if (r_int !== 1'b0) begin errors++; $display("FAIL r_in_t1 got=%0b exp=0", r_int); end
    sc_inc = 1; step(2); sc_inc = 0;  // T3, edges at T1 and T2 take no request
    checks++; if (r_int !== 1'b0 || seq !== 16'h0008) begin errors++; $display("FAIL r_before_t3 got=%0b/%h exp=0/0008", r_int, seq); end
    step(1);
    checks++; if (r_int !== 1'b1) begin errors++; $display("FAIL r_set_t3 got=%0b exp=1", r_int); end
    r_clr = 1; step(1); r_clr = 0;
    checks++; if (r_int !== 1'b0 || ien !== 1'b0) begin errors++; $display("FAIL r_clr got=%0b/%0b exp=0/0", r_int, ien); end
    fgi = 0;
    ien_set = 1; ien_clr = 1; step(1); ien_set = 0; ien_clr = 0;
    checks++; if (ien !== 1'b0) begin errors++; $display("FAIL ien_clr_wins got=%0b exp=0", ien); end
    ien_set = 1; step(1); ien_set = 0;
    fgo = 1; r_clr = 1; step(1); r_clr = 0;  // set condition with r_clr: clear wins
    checks++; if (r_int !== 1'b0) begin errors++; $display("FAIL r_clr_wins got=%0b exp=0", r_int); end
    fgo = 0;
  endtask

  task automatic test_async_reset();
    hlt = 1; step(1); hlt = 0;
    ir = 16'h6000;
    start = 1; step(1); start = 0;
    sc_inc = 1; step(4); sc_inc = 0;  // T4 with ISZ latched
    checks++; if (op !== 8'h40 || seq !== 16'h0010) begin errors++; $display("FAIL pre_reset got=%h/%h exp=40/0010", op, seq); end
    #2 rst_n = 1'b0; #1;
    checks++; if (seq !== 16'h0000 || op !== 8'h00 || sc !== 4'd0) begin errors++; $display("FAIL async_reset got=%h/%h/%0d exp=0000/00/0", seq, op, sc); end
    checks++; if ({running, ind, ien, r_int} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags got=%b exp=0000", {running, ind, ien, r_int}); end
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start_seq();
    test_decode();
    test_wrap();
    test_halt();
    test_interrupt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
